bidir_bank: RTL and testbench
=============================

// Module: bidir_bank
// PURPOSE
//  WIDTH-channel bidirectional IO bank for PP3 pads: registered output data, per-channel
//  direction FSM with guaranteed bus-turnaround dead time, registered and combinational input paths.
//  Sits between fabric logic and VPR pad primitives; supersedes single-channel BIDIR for bus-style IO.
// PARAMETERS
//  WIDTH       4        number of channels (1..32)
//  MODE        "INOUT"  "INPUT" | "OUTPUT" | "INOUT", applies to all channels
//  TURN_CYCLES 2        dead cycles with PAD_OE=0 on every direction change (0..15)
//  FILT_DEPTH  3        consecutive stable samples before filtered input changes (2..8; filter build only)
// PORTS
//  IQC     in   1      clock
//  IQR     in   1      asynchronous active-high reset
//  OQI     in   WIDTH  output data from fabric
//  OQE     in   1      output data register load enable
//  IE      in   WIDTH  requested output enable per channel
//  INEN    in   WIDTH  input buffer enable per channel
//  IQE     in   1      input capture register enable
//  PAD_I   in   WIDTH  data from pad input buffers
//  PAD_O   out  WIDTH  data to pad output drivers
//  PAD_OE  out  WIDTH  pad output-driver enable
//  IZ      out  WIDTH  combinational input data
//  IQZ     out  WIDTH  registered (optionally filtered) input data
//  BUSY    out  WIDTH  channel is in a turnaround state
// BEHAVIOUR
//  Reset (IQR=1, async): oq=0, state=RX, turn counter=0, IQZ=0, filter state=0; PAD_O=0, PAD_OE=0, BUSY=0.
//  Output data: oq<=OQI on IQC edge when OQE=1, else hold; PAD_O=oq (1-edge latency). Independent of FSM.
//  Direction FSM per channel, all registered; PAD_OE=(state==TX); BUSY=(state==TURN_TX|TURN_RX):
//   RX:      IE=1 -> TURN_TX, cnt=TURN_CYCLES (TURN_CYCLES=0 -> straight to TX).
//   TURN_TX: IE=0 -> RX (abort); else cnt-1; at cnt==1 -> TX.
//   TX:      IE=0 -> TURN_RX, cnt=TURN_CYCLES (TURN_CYCLES=0 -> straight to RX).
//   TURN_RX: always completes (IE ignored); cnt-1; at cnt==1 -> RX; RX samples IE next edge.
//  Net: PAD_OE rises TURN_CYCLES+1 edges after the first edge sampling IE=1 in RX; falls 1 edge after IE=0 in TX.
//  Input path: IZ = INEN & PAD_I (combinational, all modes except OUTPUT).
//   IQZ <= src when IQE=1 & INEN=1 & state==RX, else hold; src = PAD_I, or filtered value (see CONFIGURATION).
//   Capture blocked during TX/turnaround so IQZ never samples own driven data.
//  MODE "INPUT": FSM held in RX; PAD_OE=0, BUSY=0, PAD_O=oq (unused).
//  MODE "OUTPUT": IZ=0, IQZ=0, filter inactive; FSM operates normally (tri-statable output).
//  Reset mid-turnaround: PAD_OE=0 immediately, state RX; no residual count.
// CONFIGURATION
//  Macro BIDIR_BANK_FILTER_EN:
//   defined: per-channel glitch filter. Saturating counter counts consecutive PAD_I samples differing
//    from filtered value; filtered value toggles when count reaches FILT_DEPTH-1 on a further differing
//    sample; any matching sample clears count. Filter runs only while INEN=1 & state==RX, else cleared.
//    IQZ captures filtered value; stable step to IQZ latency = FILT_DEPTH+1 edges.
//   undefined: no filter; IQZ captures PAD_I directly; latency 1 edge; FILT_DEPTH ignored.
// STRUCTURE
//  Package bidir_bank_pkg: dir_state_t enum {RX, TURN_TX, TX, TURN_RX}, MODE string constants,
//   TURN_CNT_W=4, function for filter counter width from FILT_DEPTH.
//  Sub-module bidir_bank_chan: one channel (FSM, counter, oq bit, input reg, filter); top
//   instantiates WIDTH copies in a generate loop and shares OQE/IQE/IQC/IQR.
// TESTING
//  Reset: assert IQR mid-TX with oq=1 -> PAD_OE=0, PAD_O=0, IQZ=0, BUSY=0 same cycle, no IQC edge needed.
//  Turnaround: TURN_CYCLES=2, IE 0->1 -> BUSY=1 for 2 edges, PAD_OE=1 on 3rd edge; IE->0 -> PAD_OE=0 next edge, BUSY 2 edges.
//  Abort: TURN_CYCLES=3, IE=1 for 1 cycle then 0 -> state returns RX, PAD_OE never asserts.
//  Capture: RX, INEN=1, IQE=1, PAD_I=4'b1010 -> IQZ=4'b1010 after 1 edge (no filter); IQE=0 holds it.
//  Self-capture block: channel 0 in TX driving PAD_I[0]=1, IQE=1 -> IQZ[0] unchanged.
//  Filter (BIDIR_BANK_FILTER_EN, FILT_DEPTH=3): 2-cycle pulse on PAD_I -> IQZ unchanged; 3-cycle step -> IQZ changes at edge 4.

Source files
------------

// File: rtl/bidir_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bidir_bank_pkg
//  Description : Shared types and constants for the bidirectional IO bank:
//                direction state encoding, MODE names, turn counter width
//                and the glitch-filter counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package bidir_bank_pkg;

    typedef enum logic [1:0] {
        RX      = 2'd0,
        TURN_TX = 2'd1,
        TX      = 2'd2,
        TURN_RX = 2'd3
    } dir_state_t;

    localparam string MODE_INPUT  = "INPUT";
    localparam string MODE_OUTPUT = "OUTPUT";
    localparam string MODE_INOUT  = "INOUT";

    // Wide enough for TURN_CYCLES up to 15
    localparam int TURN_CNT_W = 4;

    // Filter counter only has to hold values 0..depth-1
    function automatic int filt_cnt_w(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 6; i++) begin
            if ((1 << w) < depth) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bidir_bank_chan.sv
`default_nettype none
// ============================================================================
//  Module      : bidir_bank_chan
//  Description : One channel of the bidirectional IO bank: output data
//                register, direction FSM with turnaround dead time, input
//                capture register and optional glitch filter.
//                Optional feature macro: BIDIR_BANK_FILTER_EN
//  Revision    : 1.0  initial release
// ============================================================================
module bidir_bank_chan
    import bidir_bank_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned FILT_DEPTH  = 3,
    parameter bit          RX_ONLY     = 1'b0,
    parameter bit          IN_OFF      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_oqi,
    input  logic i_oqe,
    input  logic i_ie,
    input  logic i_inen,
    input  logic i_iqe,
    input  logic i_pad_i,
    output logic o_pad_o,
    output logic o_pad_oe,
    output logic o_iz,
    output logic o_iqz,
    output logic o_busy
);

    localparam logic [TURN_CNT_W-1:0] c_TURN_LOAD = TURN_CNT_W'(TURN_CYCLES);
    localparam logic [TURN_CNT_W-1:0] c_TURN_ONE  = TURN_CNT_W'(1);
    localparam bit                    c_NO_TURN   = (TURN_CYCLES == 0);

    dir_state_t            r_state;
    logic [TURN_CNT_W-1:0] r_cnt;
    logic                  r_oq;
    logic                  r_iqz;
    logic                  w_ie;
    logic                  w_cap_ok;
    logic                  w_src;

    // An input-only bank never requests the driver
    assign w_ie     = i_ie & ~RX_ONLY;
    // Input side only listens while the pad is not being driven by us
    assign w_cap_ok = i_inen & (r_state == RX) & ~IN_OFF;

    // Output data register, independent of direction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oq <= 1'b0;
        end else if (i_oqe) begin
            r_oq <= i_oqi;
        end
    end

    // Direction FSM with dead-time counter on every direction change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RX;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RX: begin
                    if (w_ie) begin
                        if (c_NO_TURN) begin
                            r_state <= TX;
                        end else begin
                            r_state <= TURN_TX;
                            r_cnt   <= c_TURN_LOAD;
                        end
                    end
                end
                TURN_TX: begin
                    if (!w_ie) begin
                        r_state <= RX;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_TURN_ONE) begin
                        r_state <= TX;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                TX: begin
                    if (!w_ie) begin
                        if (c_NO_TURN) begin
                            r_state <= RX;
                        end else begin
                            r_state <= TURN_RX;
                            r_cnt   <= c_TURN_LOAD;
                        end
                    end
                end
                TURN_RX: begin
                    // Release always runs to completion so the bus gets its full dead time
                    if (r_cnt == c_TURN_ONE) begin
                        r_state <= RX;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= RX;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BIDIR_BANK_FILTER_EN
    localparam int                  c_FCNT_W   = filt_cnt_w(int'(FILT_DEPTH));
    localparam logic [c_FCNT_W-1:0] c_FCNT_TOP = c_FCNT_W'(FILT_DEPTH - 1);

    logic [c_FCNT_W-1:0] r_fcnt;
    logic                r_filt;

    // Glitch filter: flip only after FILT_DEPTH consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt <= '0;
            r_filt <= 1'b0;
        end else if (!w_cap_ok) begin
            r_fcnt <= '0;
            r_filt <= 1'b0;
        end else if (i_pad_i == r_filt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == c_FCNT_TOP) begin
            r_fcnt <= '0;
            r_filt <= ~r_filt;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    assign w_src = r_filt;
`else
    assign w_src = i_pad_i;
`endif

    // Input capture register, blocked while driving or turning around
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iqz <= 1'b0;
        end else if (i_iqe && w_cap_ok) begin
            r_iqz <= w_src;
        end
    end

    assign o_pad_o  = r_oq;
    assign o_pad_oe = (r_state == TX);
    assign o_busy   = (r_state == TURN_TX) || (r_state == TURN_RX);
    assign o_iz     = IN_OFF ? 1'b0 : (i_inen & i_pad_i);
    assign o_iqz    = r_iqz;

endmodule
`default_nettype wire

// File: rtl/bidir_bank.sv
`default_nettype none
// ============================================================================
//  Module      : bidir_bank
//  Description : WIDTH-channel bidirectional IO bank for pad primitives.
//                Registered output data, per-channel direction FSM with
//                bus-turnaround dead time, combinational and registered
//                input paths.
//                Optional feature macro: BIDIR_BANK_FILTER_EN (glitch filter)
//  Revision    : 1.0  initial release
// ============================================================================
module bidir_bank
    import bidir_bank_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter string       MODE        = "INOUT",
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned FILT_DEPTH  = 3
) (
    input  logic             IQC,
    input  logic             IQR,
    input  logic [WIDTH-1:0] OQI,
    input  logic             OQE,
    input  logic [WIDTH-1:0] IE,
    input  logic [WIDTH-1:0] INEN,
    input  logic             IQE,
    input  logic [WIDTH-1:0] PAD_I,
    output logic [WIDTH-1:0] PAD_O,
    output logic [WIDTH-1:0] PAD_OE,
    output logic [WIDTH-1:0] IZ,
    output logic [WIDTH-1:0] IQZ,
    output logic [WIDTH-1:0] BUSY
);

    localparam bit c_RX_ONLY = (MODE == MODE_INPUT);
    localparam bit c_IN_OFF  = (MODE == MODE_OUTPUT);

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_chan
        bidir_bank_chan #(
            .TURN_CYCLES (TURN_CYCLES),
            .FILT_DEPTH  (FILT_DEPTH),
            .RX_ONLY     (c_RX_ONLY),
            .IN_OFF      (c_IN_OFF)
        ) u_chan (
            .clk      (IQC),
            .rst      (IQR),
            .i_oqi    (OQI[g]),
            .i_oqe    (OQE),
            .i_ie     (IE[g]),
            .i_inen   (INEN[g]),
            .i_iqe    (IQE),
            .i_pad_i  (PAD_I[g]),
            .o_pad_o  (PAD_O[g]),
            .o_pad_oe (PAD_OE[g]),
            .o_iz     (IZ[g]),
            .o_iqz    (IQZ[g]),
            .o_busy   (BUSY[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_bidir_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bidir_bank
//  Description : Directed self-checking bench for bidir_bank. Main instance
//                uses TURN_CYCLES=2; a second instance with TURN_CYCLES=3
//                shares the inputs for the abort case.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bidir_bank;

    logic       clk;
    logic       rst;
    logic [3:0] oqi;
    logic       oqe;
    logic [3:0] ie;
    logic [3:0] inen;
    logic       iqe;
    logic [3:0] pad_i;

    logic [3:0] pad_o,  pad_oe,  iz,  iqz,  busy;
    logic [3:0] pad_o3, pad_oe3, iz3, iqz3, busy3;

    int n_checks;
    int n_errors;

    bidir_bank #(
        .WIDTH(4), .MODE("INOUT"), .TURN_CYCLES(2), .FILT_DEPTH(3)
    ) u_dut (
        .IQC(clk), .IQR(rst), .OQI(oqi), .OQE(oqe), .IE(ie), .INEN(inen),
        .IQE(iqe), .PAD_I(pad_i), .PAD_O(pad_o), .PAD_OE(pad_oe), .IZ(iz),
        .IQZ(iqz), .BUSY(busy)
    );

    bidir_bank #(
        .WIDTH(4), .MODE("INOUT"), .TURN_CYCLES(3), .FILT_DEPTH(3)
    ) u_dut3 (
        .IQC(clk), .IQR(rst), .OQI(oqi), .OQE(oqe), .IE(ie), .INEN(inen),
        .IQE(iqe), .PAD_I(pad_i), .PAD_O(pad_o3), .PAD_OE(pad_oe3), .IZ(iz3),
        .IQZ(iqz3), .BUSY(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        oqi   = '0;
        oqe   = 1'b0;
        ie    = '0;
        inen  = '0;
        iqe   = 1'b0;
        pad_i = '0;

        // Reset state
        tick();
        tick();
        check("rst_pad_o",  {28'd0, pad_o},  32'h0);
        check("rst_pad_oe", {28'd0, pad_oe}, 32'h0);
        check("rst_busy",   {28'd0, busy},   32'h0);
        check("rst_iqz",    {28'd0, iqz},    32'h0);
        rst = 1'b0;
        tick();

        // Output data register: load then hold
        oqi = 4'b0110; oqe = 1'b1;
        tick();
        check("oq_load", {28'd0, pad_o}, 32'h6);
        oqi = 4'b1111; oqe = 1'b0;
        tick();
        check("oq_hold", {28'd0, pad_o}, 32'h6);

        // Turnaround, ch0, TURN_CYCLES=2
        ie = 4'b0001;
        tick();
        check("tx_e1_busy", {28'd0, busy},   32'h1);
        check("tx_e1_oe",   {28'd0, pad_oe}, 32'h0);
        tick();
        check("tx_e2_busy", {28'd0, busy},   32'h1);
        check("tx_e2_oe",   {28'd0, pad_oe}, 32'h0);
        tick();
        check("tx_e3_oe",   {28'd0, pad_oe}, 32'h1);
        check("tx_e3_busy", {28'd0, busy},   32'h0);
        check("t3_e3_busy", {28'd0, busy3},  32'h1);
        check("t3_e3_oe",   {28'd0, pad_oe3}, 32'h0);
        ie = 4'b0000;
        tick();
        check("rx_e1_oe",   {28'd0, pad_oe}, 32'h0);
        check("rx_e1_busy", {28'd0, busy},   32'h1);
        check("t3_abort_busy", {28'd0, busy3},  32'h0);
        check("t3_abort_oe",   {28'd0, pad_oe3}, 32'h0);
        tick();
        check("rx_e2_busy", {28'd0, busy},   32'h1);
        tick();
        check("rx_e3_busy", {28'd0, busy},   32'h0);
        check("rx_e3_oe",   {28'd0, pad_oe}, 32'h0);

        // Abort after a single IE cycle, TURN_CYCLES=3
        ie = 4'b0001;
        tick();
        check("ab_busy", {28'd0, busy3}, 32'h1);
        ie = 4'b0000;
        tick();
        check("ab_back_busy", {28'd0, busy3},  32'h0);
        check("ab_back_oe",   {28'd0, pad_oe3}, 32'h0);
        tick();
        check("ab_later_oe",  {28'd0, pad_oe3}, 32'h0);

`ifdef BIDIR_BANK_FILTER_EN
        // Filter, FILT_DEPTH=3: 2-cycle pulse rejected, 3-cycle step passes at edge 4
        inen = 4'b1111; iqe = 1'b1; pad_i = 4'b0001;
        tick();
        tick();
        pad_i = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flt_pulse", {28'd0, iqz}, 32'h0);
        end
        pad_i = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flt_step_wait", {28'd0, iqz}, 32'h0);
        end
        tick();
        check("flt_step_e4", {28'd0, iqz}, 32'h1);
`else
        // Direct capture
        inen = 4'b1111; iqe = 1'b1; pad_i = 4'b1010;
        #1;
        check("iz_all", {28'd0, iz}, 32'hA);
        tick();
        check("cap_1010", {28'd0, iqz}, 32'hA);
        iqe = 1'b0; pad_i = 4'b0101;
        tick();
        check("cap_hold", {28'd0, iqz}, 32'hA);
        check("iz_new",   {28'd0, iz},  32'h5);
        inen = 4'b0011;
        #1;
        check("iz_inen", {28'd0, iz}, 32'h1);
        inen = 4'b1111;
`endif

        // Self-capture block: ch0 driving, others capture
        iqe = 1'b0;
        ie  = 4'b0001;
        tick();
        tick();
        tick();
        check("self_oe", {28'd0, pad_oe}, 32'h1);
        pad_i = 4'b1111; iqe = 1'b1;
        tick();
`ifdef BIDIR_BANK_FILTER_EN
        check("self_bit0", {31'd0, iqz[0]}, 32'h1);
`else
        check("self_bit0", {31'd0, iqz[0]}, 32'h0);
        check("self_all",  {28'd0, iqz},    32'hE);
`endif

        // Asynchronous reset mid-TX with oq=1
        oqi = 4'b1111; oqe = 1'b1;
        tick();
        check("pre_rst_pad_o", {28'd0, pad_o},  32'hF);
        check("pre_rst_oe",    {28'd0, pad_oe}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_oe",    {28'd0, pad_oe}, 32'h0);
        check("arst_pad_o", {28'd0, pad_o},  32'h0);
        check("arst_iqz",   {28'd0, iqz},    32'h0);
        check("arst_busy",  {28'd0, busy},   32'h0);
        ie = 4'b0000; oqe = 1'b0; iqe = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_oe",   {28'd0, pad_oe}, 32'h0);
        check("post_rst_busy", {28'd0, busy},   32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
